// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } state_e;

  localparam logic [4:0]  REG_ZERO   = 5'd0;
  localparam int unsigned MC_LAT_MIN = 2;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Datapath <-> stall controller bundle. The perf-counter outputs exist only with
// STALL_PERF_CNT_EN defined.
interface pipe_stall_ctrl_if;
  logic [4:0] i_id_rs;
  logic [4:0] i_id_rt;
  logic       i_id_uses_rt;
  logic       i_ex_mem_read;
  logic [4:0] i_ex_rt;
  logic       i_br_taken;
  logic       i_mc_start;
  logic       i_mem_wait;
  logic       o_pc_we;
  logic       o_ifid_we;
  logic       o_idex_we;
  logic       o_exmem_we;
  logic       o_memwb_we;
  logic       o_ifid_flush;
  logic       o_idex_bubble;
  logic       o_exmem_bubble;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] o_stall_cycles;
  logic [15:0] o_flush_count;
`endif

  modport master (
    output i_id_rs, i_id_rt, i_id_uses_rt, i_ex_mem_read, i_ex_rt,
    output i_br_taken, i_mc_start, i_mem_wait,
    input  o_pc_we, o_ifid_we, o_idex_we, o_exmem_we, o_memwb_we,
    input  o_ifid_flush, o_idex_bubble, o_exmem_bubble
`ifdef STALL_PERF_CNT_EN
    , input o_stall_cycles, o_flush_count
`endif
  );

  modport slave (
    input  i_id_rs, i_id_rt, i_id_uses_rt, i_ex_mem_read, i_ex_rt,
    input  i_br_taken, i_mc_start, i_mem_wait,
    output o_pc_we, o_ifid_we, o_idex_we, o_exmem_we, o_memwb_we,
    output o_ifid_flush, o_idex_bubble, o_exmem_bubble
`ifdef STALL_PERF_CNT_EN
    , output o_stall_cycles, o_flush_count
`endif
  );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare; shared with the forwarding unit.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rt,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_uses_rt,
  output logic       o_load_use
);

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign o_load_use = i_ex_mem_read && (i_ex_rt != REG_ZERO) &&
                      ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline write-enable / bubble sequencer. Optional perf counters under the
// STALL_PERF_CNT_EN macro.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned CNT_W  = 8
) (
  input logic              clk,
  input logic              rst,
  pipe_stall_ctrl_if.slave bus
);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_load_use;
  logic             w_pc_we, w_ifid_we, w_idex_we, w_exmem_we, w_memwb_we;
  logic             w_ifid_flush, w_idex_bubble, w_exmem_bubble;

  load_use_detect u_load_use (
    .i_ex_mem_read (bus.i_ex_mem_read),
    .i_ex_rt       (bus.i_ex_rt),
    .i_id_rs       (bus.i_id_rs),
    .i_id_rt       (bus.i_id_rt),
    .i_id_uses_rt  (bus.i_id_uses_rt),
    .o_load_use    (w_load_use)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_pc_we        = 1'b1;
    w_ifid_we      = 1'b1;
    w_idex_we      = 1'b1;
    w_exmem_we     = 1'b1;
    w_memwb_we     = 1'b1;
    w_ifid_flush   = 1'b0;
    w_idex_bubble  = 1'b0;
    w_exmem_bubble = 1'b0;
    if (rst) begin
      {w_pc_we, w_ifid_we, w_idex_we, w_exmem_we, w_memwb_we} = '0;
    end else if (bus.i_mem_wait) begin
      // Frozen pipe still ages the multi-cycle op; exit waits for mem_wait to drop.
      {w_pc_we, w_ifid_we, w_idex_we, w_exmem_we, w_memwb_we} = '0;
      if (r_cnt != '0) w_cnt_nxt = r_cnt - CNT_W'(1);
    end else if ((r_state == MC_BUSY) && (r_cnt != '0)) begin
      {w_pc_we, w_ifid_we, w_idex_we} = '0;
      w_exmem_bubble = 1'b1;
      w_cnt_nxt      = r_cnt - CNT_W'(1);
    end else if ((r_state == RUN) && bus.i_mc_start) begin
      {w_pc_we, w_ifid_we, w_idex_we} = '0;
      w_exmem_bubble = 1'b1;
      w_cnt_nxt      = CNT_W'(MC_LAT - MC_LAT_MIN);
      w_state_nxt    = MC_BUSY;
    end else begin
      w_state_nxt = RUN;
      // A load-use stall suppresses the branch; it is re-evaluated next cycle.
      if (w_load_use) begin
        w_pc_we       = 1'b0;
        w_ifid_we     = 1'b0;
        w_idex_bubble = 1'b1;
      end else if (bus.i_br_taken) begin
        w_ifid_flush = 1'b1;
      end
    end
  end

  assign bus.o_pc_we        = w_pc_we;
  assign bus.o_ifid_we      = w_ifid_we;
  assign bus.o_idex_we      = w_idex_we;
  assign bus.o_exmem_we     = w_exmem_we;
  assign bus.o_memwb_we     = w_memwb_we;
  assign bus.o_ifid_flush   = w_ifid_flush;
  assign bus.o_idex_bubble  = w_idex_bubble;
  assign bus.o_exmem_bubble = w_exmem_bubble;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [15:0] r_flush_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (!w_pc_we && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_ifid_flush && (r_flush_count != '1)) r_flush_count <= r_flush_count + 16'd1;
    end
  end

  assign bus.o_stall_cycles = r_stall_cycles;
  assign bus.o_flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench: directed scenarios plus randomized cycles against a
// behavioural occupancy model, on two instances (MC_LAT=4 and MC_LAT=2).
module tb_pipe_stall_ctrl;

  // Packed as {pc, ifid, idex, exmem, memwb, ifid_flush, idex_bubble, exmem_bubble}
  localparam logic [7:0] E_NORM = 8'b11111_000;
  localparam logic [7:0] E_BR   = 8'b11111_100;
  localparam logic [7:0] E_LU   = 8'b00111_010;
  localparam logic [7:0] E_MC   = 8'b00011_001;
  localparam logic [7:0] E_OFF  = 8'b00000_000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic       id_uses_rt = 1'b0, ex_mem_read = 1'b0, br_taken = 1'b0;
  logic       mc_start = 1'b0, mem_wait = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  bit m_in_op[2];
  int m_age[2];
  int m_lat[2] = '{4, 2};

  always #5 clk = ~clk;

  pipe_stall_ctrl_if ifa ();
  pipe_stall_ctrl_if ifb ();

  assign ifa.i_id_rs = id_rs;        assign ifb.i_id_rs = id_rs;
  assign ifa.i_id_rt = id_rt;        assign ifb.i_id_rt = id_rt;
  assign ifa.i_id_uses_rt = id_uses_rt;   assign ifb.i_id_uses_rt = id_uses_rt;
  assign ifa.i_ex_mem_read = ex_mem_read; assign ifb.i_ex_mem_read = ex_mem_read;
  assign ifa.i_ex_rt = ex_rt;        assign ifb.i_ex_rt = ex_rt;
  assign ifa.i_br_taken = br_taken;  assign ifb.i_br_taken = br_taken;
  assign ifa.i_mc_start = mc_start;  assign ifb.i_mc_start = mc_start;
  assign ifa.i_mem_wait = mem_wait;  assign ifb.i_mem_wait = mem_wait;

  pipe_stall_ctrl #(.MC_LAT(4), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  pipe_stall_ctrl #(.MC_LAT(2), .CNT_W(8)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  function automatic logic [7:0] outs_a();
    return {ifa.o_pc_we, ifa.o_ifid_we, ifa.o_idex_we, ifa.o_exmem_we, ifa.o_memwb_we,
            ifa.o_ifid_flush, ifa.o_idex_bubble, ifa.o_exmem_bubble};
  endfunction

  function automatic logic [7:0] outs_b();
    return {ifb.o_pc_we, ifb.o_ifid_we, ifb.o_idex_we, ifb.o_exmem_we, ifb.o_memwb_we,
            ifb.o_ifid_flush, ifb.o_idex_bubble, ifb.o_exmem_bubble};
  endfunction

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rt = '0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
    br_taken = 1'b0; mc_start = 1'b0; mem_wait = 1'b0;
  endtask

  // Leaves time at a falling edge with reset released and inputs idle.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_in_op[k] = 1'b0;
      m_age[k]   = 0;
    end
  endtask

  // Model: an op in EX has an age counted in cycles since it entered (frozen
  // cycles included); it stalls until age reaches MC_LAT-1 and leaves on the
  // first unfrozen cycle after that.
  task automatic model_step(input int k, output logic [7:0] exp);
    bit lu;
    lu = ex_mem_read && (ex_rt != 5'd0) &&
         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    if (rst) begin
      exp = E_OFF; m_in_op[k] = 1'b0; m_age[k] = 0;
    end else if (mem_wait) begin
      exp = E_OFF;
      if (m_in_op[k]) m_age[k]++;
    end else if (m_in_op[k] && (m_age[k] < m_lat[k] - 1)) begin
      exp = E_MC; m_age[k]++;
    end else if (!m_in_op[k] && mc_start) begin
      exp = E_MC; m_in_op[k] = 1'b1; m_age[k] = 1;
    end else begin
      m_in_op[k] = 1'b0;
      exp = lu ? E_LU : (br_taken ? E_BR : E_NORM);
    end
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if (outs_a() !== E_OFF) begin n_fail++; $display("FAIL rst_hold: got %b want %b", outs_a(), E_OFF); end
    do_reset();
    #1;
    n_tests++;
    if (outs_a() !== E_NORM) begin n_fail++; $display("FAIL rst_release: got %b want %b", outs_a(), E_NORM); end
`ifdef STALL_PERF_CNT_EN
    n_tests++;
    if (ifa.o_stall_cycles !== 32'd0 || ifa.o_flush_count !== 16'd0) begin
      n_fail++; $display("FAIL perf_rst: got %0d/%0d want 0/0", ifa.o_stall_cycles, ifa.o_flush_count);
    end
`endif
    mc_start = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (outs_a() !== E_OFF) begin n_fail++; $display("FAIL rst_async: got %b want %b", outs_a(), E_OFF); end
    @(negedge clk);
    rst = 1'b0; mc_start = 1'b0;
    #1;
    n_tests++;
    if (outs_a() !== E_NORM) begin n_fail++; $display("FAIL rst_abort_mc: got %b want %b", outs_a(), E_NORM); end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    #1;
    n_tests++;
    if (outs_a() !== E_LU) begin n_fail++; $display("FAIL lu_stall: got %b want %b", outs_a(), E_LU); end
    @(negedge clk);
    ex_mem_read = 1'b0;
    #1;
    n_tests++;
    if (outs_a() !== E_NORM) begin n_fail++; $display("FAIL lu_one_cycle: got %b want %b", outs_a(), E_NORM); end
    @(negedge clk);
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
    #1;
    n_tests++;
    if (outs_a() !== E_NORM) begin n_fail++; $display("FAIL lu_r0: got %b want %b", outs_a(), E_NORM); end
    ex_rt = 5'd5; id_rs = 5'd1; id_rt = 5'd5; id_uses_rt = 1'b0;
    #1;
    n_tests++;
    if (outs_a() !== E_NORM) begin n_fail++; $display("FAIL lu_rt_unused: got %b want %b", outs_a(), E_NORM); end
    id_uses_rt = 1'b1;
    #1;
    n_tests++;
    if (outs_a() !== E_LU) begin n_fail++; $display("FAIL lu_rt_used: got %b want %b", outs_a(), E_LU); end
  endtask

  task automatic test_priority();
    do_reset();
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; br_taken = 1'b1;
    #1;
    n_tests++;
    if (outs_a() !== E_LU) begin n_fail++; $display("FAIL prio_lu_over_br: got %b want %b", outs_a(), E_LU); end
    @(negedge clk);
    ex_mem_read = 1'b0;
    #1;
    n_tests++;
    if (outs_a() !== E_BR) begin n_fail++; $display("FAIL prio_br_retry: got %b want %b", outs_a(), E_BR); end
  endtask

  task automatic test_multicycle();
    do_reset();
    mc_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if (outs_a() !== ((i < 3) ? E_MC : E_NORM)) begin
        n_fail++; $display("FAIL mc4_cycle%0d: got %b want %b", i, outs_a(), (i < 3) ? E_MC : E_NORM);
      end
      @(negedge clk);
    end
    mc_start = 1'b0;
    #1;
    n_tests++;
    if (outs_a() !== E_NORM) begin n_fail++; $display("FAIL mc4_after: got %b want %b", outs_a(), E_NORM); end
    mc_start = 1'b1;
    #1;
    n_tests++;
    if (outs_a() !== E_MC) begin n_fail++; $display("FAIL mc4_restart: got %b want %b", outs_a(), E_MC); end
  endtask

  task automatic test_mc_lat2();
    do_reset();
    mc_start = 1'b1;
    #1;
    n_tests++;
    if (outs_b() !== E_MC) begin n_fail++; $display("FAIL mc2_stall: got %b want %b", outs_b(), E_MC); end
    @(negedge clk);
    #1;
    n_tests++;
    if (outs_b() !== E_NORM) begin n_fail++; $display("FAIL mc2_final: got %b want %b", outs_b(), E_NORM); end
    @(negedge clk);
    mc_start = 1'b0;
    #1;
    n_tests++;
    if (outs_b() !== E_NORM) begin n_fail++; $display("FAIL mc2_after: got %b want %b", outs_b(), E_NORM); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    mc_start = 1'b1;
    @(negedge clk);
    mem_wait = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if (outs_a() !== E_OFF) begin n_fail++; $display("FAIL mw_freeze%0d: got %b want %b", i, outs_a(), E_OFF); end
      @(negedge clk);
    end
    mem_wait = 1'b0;
    #1;
    n_tests++;
    if (outs_a() !== E_NORM) begin n_fail++; $display("FAIL mw_mc_exit: got %b want %b", outs_a(), E_NORM); end
    @(negedge clk);
    mc_start = 1'b0; mem_wait = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd3; id_rs = 5'd3;
    #1;
    n_tests++;
    if (outs_a() !== E_OFF) begin n_fail++; $display("FAIL mw_over_lu: got %b want %b", outs_a(), E_OFF); end
  endtask

  task automatic test_random();
    logic [7:0] ea, eb;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rst         = ($urandom_range(0, 99) == 0);
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      ex_rt       = 5'($urandom_range(0, 3));
      id_uses_rt  = 1'($urandom_range(0, 1));
      ex_mem_read = ($urandom_range(0, 2) == 0);
      br_taken    = ($urandom_range(0, 3) == 0);
      mc_start    = ($urandom_range(0, 5) == 0);
      mem_wait    = ($urandom_range(0, 4) == 0);
      #1;
      model_step(0, ea);
      model_step(1, eb);
      n_tests++;
      if (outs_a() !== ea) begin n_fail++; $display("FAIL rand_lat4 c%0d: got %b want %b", c, outs_a(), ea); end
      n_tests++;
      if (outs_b() !== eb) begin n_fail++; $display("FAIL rand_lat2 c%0d: got %b want %b", c, outs_b(), eb); end
    end
    rst = 1'b0;
  endtask

`ifdef STALL_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; br_taken = 1'b1;
    @(negedge clk);
    ex_mem_read = 1'b0;
    @(negedge clk);
    br_taken = 1'b0; mc_start = 1'b1;
    repeat (4) @(negedge clk);
    mc_start = 1'b0;
    #1;
    n_tests++;
    if (ifa.o_stall_cycles !== 32'd4) begin
      n_fail++; $display("FAIL perf_stall: got %0d want 4", ifa.o_stall_cycles);
    end
    n_tests++;
    if (ifa.o_flush_count !== 16'd1) begin
      n_fail++; $display("FAIL perf_flush: got %0d want 1", ifa.o_flush_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_priority();
    test_multicycle();
    test_mc_lat2();
    test_mem_wait();
    test_random();
`ifdef STALL_PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
